i2c_reg_target: RTL
===================

I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 The module SHALL have parameter CHIP_ADDR, default 7'h21, giving the 7-bit target address it answers to.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops (minimum 2).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock, at least 16x the SCL rate.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port scl_in, input, 1 bit: the asynchronous bus SCL level.
REQ-006 The module SHALL have port sda_in, input, 1 bit: the asynchronous bus SDA level.
REQ-007 The module SHALL have port sda_oe, output, 1 bit: 1 drives SDA low (open drain); 0 releases SDA.
REQ-008 The module SHALL have port reg_addr, output, 8 bits: the current register subaddress.
REQ-009 The module SHALL have port wr_en, output, 1 bit: a one-cycle write strobe.
REQ-010 The module SHALL have port wr_data, output, 8 bits: write data, valid while wr_en=1.
REQ-011 The module SHALL have port rd_data, input, 8 bits: register contents at reg_addr, valid 2 clk cycles after reg_addr changes.
REQ-012 The module SHALL have port busy, output, 1 bit: 1 from an addressed START until STOP or NACK.

Function
REQ-013 The module SHALL synchronize scl_in and sda_in through SYNC_STAGES flops and derive one-cycle scl_rise and scl_fall events from the synchronized levels.
REQ-014 The module SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; a START received in any state, including a repeated START, SHALL enter ADDR.
REQ-015 The module SHALL use states IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA and RDATA_ACK.
REQ-016 The module SHALL sample SDA at scl_rise, MSB first, and SHALL change sda_oe only in the cycle after scl_fall.
REQ-017 ADDR SHALL shift in 8 bits; a match on bits[7:1] SHALL go to ADDR_ACK with sda_oe=1 for one SCL period, and a mismatch SHALL go to IDLE with sda_oe=0.
REQ-018 After ADDR_ACK, R/W=0 SHALL go to SUB; R/W=1 SHALL go to RDATA, loading the shift register from rd_data in the scl_fall cycle that ends the ACK.
REQ-019 SUB SHALL load the received byte into reg_addr, ACK it, and then go to WDATA.
REQ-020 Each WDATA byte SHALL be ACKed; wr_en SHALL pulse for exactly one cycle at the scl_rise of the 8th bit with wr_data equal to the byte; reg_addr SHALL then increment modulo 256 (0xFF wraps to 0x00).
REQ-021 RDATA SHALL drive sda_oe=~bit for each bit; in RDATA_ACK the module SHALL release SDA and sample the controller's ACK.
REQ-022 On ACK (SDA=0), reg_addr SHALL increment modulo 256 and the next byte SHALL load from rd_data at the scl_fall ending the ACK; on NACK the module SHALL go to IDLE.
REQ-023 STOP SHALL force IDLE and release sda_oe; a partial byte SHALL be discarded with no wr_en.
REQ-024 busy SHALL rise in the cycle ADDR_ACK is entered and fall in the cycle IDLE is entered.

Reset
REQ-025 Reset SHALL set state=IDLE, sda_oe=0, wr_en=0, wr_data=0, reg_addr=0, busy=0 and clear the synchronizers to 1, including when reset is asserted mid-transaction.
REQ-026 After reset deasserts, the module SHALL ignore bus activity until the next START.

Configuration
REQ-027 With I2C_TARGET_GLITCH_FILTER_EN defined, SCL and SDA SHALL each pass through a 3-sample majority filter after synchronization, adding 2 cycles of latency; without it the synchronized levels SHALL be used directly.

Structure
REQ-028 A shared package i2c_pkg SHALL hold the state encoding, the START/STOP/ACK constants and the default CHIP_ADDR.
REQ-029 Synchronization, optional filtering and edge/START/STOP detection SHALL be one sub-module, i2c_bus_sampler.

Verification
REQ-030 The bench SHALL drive a write S,0x42,0x3A,0x12,P and require 3 ACKs, one wr_en with wr_data=0x12 and reg_addr=0x3A, and then reg_addr=0x3B.
REQ-031 The bench SHALL drive a read S,0x42,0x10,Sr,0x43,(ACK),(NACK),P with rd_data=reg_addr+1 and require the bytes 0x11 and 0x12 on SDA, busy=0 after the NACK.
REQ-032 The bench SHALL drive an address mismatch S,0x44,... and require sda_oe=0 throughout, no wr_en and busy=0.
REQ-033 The bench SHALL drive a write starting at subaddress 0xFF with two data bytes and require wr_en at 0xFF and then at 0x00.
REQ-034 The bench SHALL drive STOP after 4 bits of a data byte and require no wr_en and IDLE within 1 cycle.
REQ-035 The bench SHALL assert reset during RDATA while a bit is being driven low and require sda_oe=0 in the next cycle and a correct ACK on the following transaction.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, bus-condition constants and defaults for the I2C register target.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_e;

    localparam logic [6:0] DEFAULT_CHIP_ADDR = 7'h21;

    // {previous, current} SDA level while SCL stays high
    localparam logic [1:0] START_SDA_EDGE = 2'b10;
    localparam logic [1:0] STOP_SDA_EDGE  = 2'b01;

    localparam logic       SDA_ACK       = 1'b0;
    localparam logic       SDA_NACK      = 1'b1;
    localparam logic       RW_READ       = 1'b1;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_bus_sampler.sv
// i2c_bus_sampler: synchronizes SCL/SDA, optional 3-sample majority filter (I2C_TARGET_GLITCH_FILTER_EN), edge/START/STOP detect.
// Latency: SYNC_STAGES clk pin-to-level (+2 with filter); events are combinational from the levels.
// Backpressure: none; events are single-cycle pulses.
module i2c_bus_sampler
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [STAGES-1:0] sda_sync_q, sda_sync_d;
    logic              scl_prev_q, scl_prev_d;
    logic              sda_prev_q, sda_prev_d;
    logic              scl_lvl, sda_lvl;

    always_comb begin
        scl_sync_d = {scl_sync_q[STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[STAGES-2:0], sda_in};
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d;
    logic [1:0] sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d;
    logic       sda_filt_q, sda_filt_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[STAGES-1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[STAGES-1]};
        scl_filt_d = maj3(scl_sync_q[STAGES-1], scl_hist_q[0], scl_hist_q[1]);
        sda_filt_d = maj3(sda_sync_q[STAGES-1], sda_hist_q[0], sda_hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_lvl = scl_filt_q;
    assign sda_lvl = sda_filt_q;
`else
    assign scl_lvl = scl_sync_q[STAGES-1];
    assign sda_lvl = sda_sync_q[STAGES-1];
`endif

    always_comb begin
        scl_prev_d = scl_lvl;
        sda_prev_d = sda_lvl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign sda       = sda_lvl;
    assign scl_rise  = scl_lvl & ~scl_prev_q;
    assign scl_fall  = ~scl_lvl & scl_prev_q;
    assign start_det = scl_lvl & scl_prev_q & ({sda_prev_q, sda_lvl} == START_SDA_EDGE);
    assign stop_det  = scl_lvl & scl_prev_q & ({sda_prev_q, sda_lvl} == STOP_SDA_EDGE);

endmodule

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target mapping bus writes/reads onto an 8-bit register port (filter: I2C_TARGET_GLITCH_FILTER_EN).
// Latency: bus events reach the FSM SYNC_STAGES clk after the pins (+2 filtered); wr_en registered off the 8th SCL rise.
// Backpressure: none; register port takes wr_en any cycle and returns rd_data within 2 clk of reg_addr changing.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] CHIP_ADDR   = DEFAULT_CHIP_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       wr_en,
    output logic [7:0] wr_data,
    input  logic [7:0] rd_data,
    output logic       busy
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_e     state_q, state_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;

    logic       byte_full;
    logic       addr_match;
    logic [7:0] shift_in;

    assign byte_full  = (bit_cnt_q == BITS_PER_BYTE);
    assign addr_match = (shift_q[7:1] == CHIP_ADDR);
    assign shift_in   = {shift_q[6:0], sda};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR:      if (scl_fall && byte_full) state_d = addr_match ? ST_ADDR_ACK : ST_IDLE;
                ST_ADDR_ACK:  if (scl_fall) state_d = (shift_q[0] == RW_READ) ? ST_RDATA : ST_SUB;
                ST_SUB:       if (scl_fall && byte_full) state_d = ST_SUB_ACK;
                ST_SUB_ACK:   if (scl_fall) state_d = ST_WDATA;
                ST_WDATA:     if (scl_fall && byte_full) state_d = ST_WDATA_ACK;
                ST_WDATA_ACK: if (scl_fall) state_d = ST_WDATA;
                ST_RDATA:     if (scl_fall && byte_full) state_d = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    if (scl_rise && sda == SDA_NACK) state_d = ST_IDLE;
                    else if (scl_fall)               state_d = ST_RDATA;
                end
                default:      state_d = state_q;
            endcase
        end
    end

    // Write address advances the cycle after the strobe so wr_en sees the target address.
    always_comb begin
        sda_oe_d   = sda_oe_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        reg_addr_d = wr_en_q ? reg_addr_q + 8'd1 : reg_addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;

        busy_d = busy_q;
        if (state_d == ST_IDLE)          busy_d = 1'b0;
        else if (state_d == ST_ADDR_ACK) busy_d = 1'b1;

        if (stop_det || start_det) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_ADDR, ST_SUB, ST_WDATA: begin
                    if (scl_rise && !byte_full) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == ST_WDATA && bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = shift_in;
                        end
                    end
                    if (scl_fall && byte_full) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = (state_q != ST_ADDR) || addr_match;
                        if (state_q == ST_SUB) reg_addr_d = shift_q;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0] == RW_READ) begin
                            shift_d  = rd_data;
                            sda_oe_d = ~rd_data[7];
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (byte_full) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    // Bump on the ACK rise so rd_data has settled by the closing fall.
                    if (scl_rise && sda == SDA_ACK) reg_addr_d = reg_addr_q + 8'd1;
                    if (scl_fall) begin
                        shift_d   = rd_data;
                        sda_oe_d  = ~rd_data[7];
                        bit_cnt_d = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sda_oe_q   <= 1'b0;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 4'd0;
            reg_addr_q <= 8'h00;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            sda_oe_q   <= sda_oe_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            reg_addr_q <= reg_addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign reg_addr = reg_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule
